// File: rtl/player_input_ctrl_pkg.sv
// Shared definitions for the player input front end: button indices and the
// per-button debounce state encoding (also referenced by the bench).
package player_input_ctrl_pkg;

  localparam int BTN_BEGIN = 0;
  localparam int BTN_PLAY  = 1;
  localparam int BTN_RESET = 2;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/player_input_ctrl_btn_debounce.sv
// One button lane: 2-FF synchroniser, 4-state debounce FSM with a stability
// counter, and a registered one-clk press pulse.
// Optional: PLAYER_AUTOREPEAT_EN adds a hold counter that re-fires the pulse
// every REPEAT_CYCLES clk while the button stays pressed.
module player_input_ctrl_btn_debounce
  import player_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
`ifdef PLAYER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 50_000_000
`endif
) (
  input  logic clk,
  input  logic Rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta, sync_q;
  db_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, pulse_nxt;

`ifdef PLAYER_AUTOREPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rcnt, rcnt_nxt;

  // hold counter only advances while sitting in PRESSED
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) rcnt <= '0;
    else        rcnt <= rcnt_nxt;
`endif

  // two-stage synchroniser; only sync_q is seen by the FSM
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end

  // state, counter, level and pulse registers
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) begin
      state       <= ST_RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      press_pulse <= pulse_nxt;
    end

  // next-state: a level change is accepted after DEBOUNCE_CYCLES stable samples;
  // the >= compare keeps the counter from ever running past its last value
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    pulse_nxt = 1'b0;
`ifdef PLAYER_AUTOREPEAT_EN
    rcnt_nxt  = '0;
`endif
    case (state)
      ST_RELEASED:
        if (sync_q) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      ST_PRESS_WAIT:
        if (!sync_q) begin
          state_nxt = ST_RELEASED;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      ST_PRESSED:
        if (!sync_q) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
`ifdef PLAYER_AUTOREPEAT_EN
        else if (rcnt >= RPT_LAST) begin
          pulse_nxt = 1'b1;
        end else begin
          rcnt_nxt  = rcnt + RPT_W'(1);
        end
`endif
      ST_RELEASE_WAIT:
        if (sync_q) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = ST_RELEASED;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      default: begin
        state_nxt = ST_RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/player_input_ctrl.sv
// Player input front end: one debounce lane per button, then a pending latch
// that turns each clk-domain press into a strobe lasting one full slow period.
// Optional feature macro: PLAYER_AUTOREPEAT_EN (hold-to-repeat press pulses).
module player_input_ctrl
  import player_input_ctrl_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_CYCLES   = 50_000_000
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             slw_tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic             Begin_btn,
  output logic             Play_btn,
  output logic             Reset
);

  // elaboration-time sanity on the configuration
  if (N_BTN < 3) begin : g_bad_nbtn
    $error("player_input_ctrl: N_BTN must cover Begin/Play/Reset");
  end
  if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_db
    $error("player_input_ctrl: CNT_W too narrow or DEBOUNCE_CYCLES < 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rpt
    $error("player_input_ctrl: REPEAT_CYCLES must be positive");
  end

  logic [N_BTN-1:0] pend, strobe;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    player_input_ctrl_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef PLAYER_AUTOREPEAT_EN
      ,
      .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
    ) u_db (
      .clk        (clk),
      .Rst_n      (Rst_n),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .press_pulse(press_pulse[i])
    );
  end

  // strobes move only on slw_tick; a pulse landing on the tick cycle is kept
  // in pend so it shows at the next tick instead of being lost
  always_ff @(posedge clk or negedge Rst_n)
    if (!Rst_n) begin
      pend   <= '0;
      strobe <= '0;
    end else if (slw_tick) begin
      strobe <= pend;
      pend   <= press_pulse;
    end else begin
      pend   <= pend | press_pulse;
    end

  assign Begin_btn = strobe[BTN_BEGIN];
  assign Play_btn  = strobe[BTN_PLAY];
  assign Reset     = strobe[BTN_RESET];

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: per-cycle comparison against a run-length
// reference model, a table of press patterns, hand sequences for tick
// coincidence / merging / reset / auto-repeat, and a random pin stream.
module tb_player_input_ctrl;
  import player_input_ctrl_pkg::*;

  localparam int DC  = 4;
  localparam int RPT = 16;
  localparam int TP  = 10;
`ifdef PLAYER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, slw_tick = 1'b0;
  logic [2:0] btn_raw = '0, btn_level, press_pulse;
  logic       Begin_btn, Play_btn, Reset;

  player_input_ctrl #(
    .N_BTN(3), .DEBOUNCE_CYCLES(DC), .CNT_W(3), .REPEAT_CYCLES(RPT)
  ) u_dut (
    .clk(clk), .Rst_n(rst_n), .btn_raw(btn_raw), .slw_tick(slw_tick),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .Begin_btn(Begin_btn), .Play_btn(Play_btn), .Reset(Reset)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, ncyc = 0, tphase = 0;
  bit tick_en = 1'b1;
  int pl_cnt[3], st_cnt[3];

  // reference model: the pin is seen two clocks late; the accepted level flips
  // once the seen value has differed from it for DC samples in a row
  bit [2:0] m_s1, m_s2, m_lvl, m_pulse, m_pend, m_strobe;
  int       m_run[3], m_held[3];

  function void model_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_pend = '0; m_strobe = '0;
    for (int b = 0; b < 3; b++) begin m_run[b] = 0; m_held[b] = 0; end
  endfunction

  function void model_step(input bit [2:0] raw, input bit tick);
    bit [2:0] np;
    np = '0;
    if (tick) begin m_strobe = m_pend; m_pend = m_pulse; end
    else m_pend = m_pend | m_pulse;
    for (int b = 0; b < 3; b++) begin
      bit s;
      s = m_s2[b];
      if (s != m_lvl[b]) begin
        m_held[b] = 0;
        m_run[b]++;
        if (m_run[b] == DC) begin m_lvl[b] = s; m_run[b] = 0; np[b] = s; end
      end else if (m_run[b] != 0) begin
        m_run[b] = 0; m_held[b] = 0;   // aborted change: hold time restarts
      end else if (AR && m_lvl[b]) begin
        m_held[b]++;
        if (m_held[b] == RPT) begin np[b] = 1'b1; m_held[b] = 0; end
      end
    end
    m_s2 = m_s1; m_s1 = raw; m_pulse = np;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", name, got, exp, ncyc);
    end
  endtask

  task automatic check_state();
    logic [8:0] got, exp;
    got = {btn_level, press_pulse, Reset, Play_btn, Begin_btn};
    exp = {m_lvl, m_pulse, m_strobe};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_model cyc=%0d got lvl/pulse/strobe=%b want=%b", ncyc, got, exp);
    end
  endtask

  // one clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input logic [2:0] raw);
    logic [2:0] st;
    btn_raw  = raw;
    slw_tick = tick_en && (tphase == TP - 1);
    @(posedge clk);
    if (rst_n) model_step(btn_raw, slw_tick); else model_clear();
    tphase = (tphase + 1) % TP;
    ncyc++;
    @(negedge clk);
    check_state();
    st = {Reset, Play_btn, Begin_btn};
    for (int b = 0; b < 3; b++) begin
      pl_cnt[b] += int'(press_pulse[b]);
      st_cnt[b] += int'(st[b]);
    end
  endtask

  task automatic wait_phase(input int ph);
    while (tphase != ph) cyc(3'b000);
  endtask

  task automatic clr_counts();
    for (int b = 0; b < 3; b++) begin pl_cnt[b] = 0; st_cnt[b] = 0; end
  endtask

  typedef struct {
    logic [2:0] mask;
    int hi, lo, reps;
    int p0, p1, p2, s0, s1, s2;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc %0d", ncyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fp, fs, fb;
    int idx[$];
    int rem[3];
    logic [2:0] cur;

    // press pattern table: expected press pulses and strobe-high cycles per button
    vecs[0] = '{3'b010, 14, 30, 1, 0, 1, 0, 0, 10, 0};  // single Play press
    vecs[1] = '{3'b001,  3,  3, 6, 0, 0, 0, 0,  0, 0};  // Begin glitches 3/3
    vecs[2] = '{3'b101, 14, 30, 1, 1, 0, 1, 10, 0, 10}; // Begin+Reset together
    vecs[3] = '{3'b111,  4, 30, 1, 1, 1, 1, 10, 10, 10}; // exactly DC high
    vecs[4] = '{3'b010,  3,  5, 4, 0, 0, 0, 0,  0, 0};  // DC-1 high, no press

    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({btn_level, press_pulse, Reset, Play_btn, Begin_btn}), 0);
    rst_n = 1'b1;
    repeat (5) cyc(3'b000);

    for (int v = 0; v < 5; v++) begin
      clr_counts();
      for (int r = 0; r < vecs[v].reps; r++) begin
        repeat (vecs[v].hi) cyc(vecs[v].mask);
        repeat (vecs[v].lo) cyc(3'b000);
      end
      repeat (40) cyc(3'b000);
      chk($sformatf("vec%0d_pulse_begin", v), pl_cnt[0], vecs[v].p0);
      chk($sformatf("vec%0d_pulse_play",  v), pl_cnt[1], vecs[v].p1);
      chk($sformatf("vec%0d_pulse_reset", v), pl_cnt[2], vecs[v].p2);
      chk($sformatf("vec%0d_strobe_begin", v), st_cnt[0], vecs[v].s0);
      chk($sformatf("vec%0d_strobe_play",  v), st_cnt[1], vecs[v].s1);
      chk($sformatf("vec%0d_strobe_reset", v), st_cnt[2], vecs[v].s2);
    end

    // pulse lands on a tick cycle: strobe must wait for the following tick
    wait_phase(3);
    fp = -1; fs = -1;
    for (int k = 0; k < 32; k++) begin
      cyc(k < 14 ? 3'b010 : 3'b000);
      if (fp < 0 && press_pulse[1]) fp = k;
      if (fs < 0 && Play_btn) fs = k;
      if (k == 6) chk("coinc_no_strobe_on_tick", int'(Play_btn), 0);
    end
    chk("coinc_pulse_latency", fp, 5);
    chk("coinc_strobe_next_tick", fs, 16);

    // two Play presses between the same pair of ticks merge into one strobe
    wait_phase(4);
    clr_counts();
    fs = -1;
    for (int k = 0; k < 45; k++) begin
      cyc((k < 4 || (k >= 8 && k < 14)) ? 3'b010 : 3'b000);
      if (fs < 0 && Play_btn) fs = k;
    end
    chk("merge_pulses", pl_cnt[1], 2);
    chk("merge_strobe_cycles", st_cnt[1], 10);
    chk("merge_strobe_start", fs, 15);

    // async reset with Begin mid-debounce and Play pending
    wait_phase(0);
    for (int k = 0; k < 9; k++) cyc(k >= 5 ? 3'b011 : 3'b010);
    chk("rst_pre_begin_state", int'(u_dut.g_btn[0].u_db.state), int'(ST_PRESS_WAIT));
    chk("rst_pre_play_pend", int'(u_dut.pend[1]), 1);
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_async_outputs", int'({btn_level, press_pulse, Reset, Play_btn, Begin_btn}), 0);
    chk("rst_begin_state", int'(u_dut.g_btn[0].u_db.state), int'(ST_RELEASED));
    repeat (3) cyc(3'b011);
    rst_n = 1'b1;
    fb = -1; fp = -1;
    for (int k = 0; k < 12; k++) begin
      cyc(3'b011);
      if (fb < 0 && press_pulse[0]) fb = k;
      if (fp < 0 && press_pulse[1]) fp = k;
    end
    chk("rst_redebounce_begin", fb, 5);
    chk("rst_redebounce_play", fp, 5);
    repeat (40) cyc(3'b000);

    // long hold: repeat pulses only when auto-repeat is built in
    for (int k = 0; k < 75; k++) begin
      cyc(k < 60 ? 3'b010 : 3'b000);
      if (press_pulse[1]) idx.push_back(k);
    end
    chk("hold_pulse_count", idx.size(), AR ? 4 : 1);
    for (int i = 0; i < idx.size(); i++) chk($sformatf("hold_pulse%0d_time", i), idx[i], 5 + RPT * i);
    repeat (30) cyc(3'b000);

    // random pin activity with tick stalls, checked against the model each cycle
    cur = '0;
    for (int b = 0; b < 3; b++) rem[b] = $urandom_range(1, 12);
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) tick_en = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin cur[b] = ~cur[b]; rem[b] = $urandom_range(1, 12); end
        else rem[b]--;
      end
      cyc(cur);
    end
    tick_en = 1'b1;
    repeat (40) cyc(3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
